// File: rtl/q2_pkg.sv
// Shared encodings for the Q2 cycle sequencer: state bits, phases and front-panel operations.
package q2_pkg;

    // Values are the {s3,s2,s1,s0} patterns the control decoder expects.
    typedef enum logic [3:0] {
        ST_FETCH = 4'b0000,
        ST_DEREF = 4'b0001,
        ST_LOAD  = 4'b0010,
        ST_EXEC  = 4'b0011,
        ST_SHIFT = 4'b0100,
        ST_FINAL = 4'b1000
    } state_t;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        PNL_IDLE = 2'd0,
        PNL_DEP  = 2'd1,
        PNL_INC  = 2'd2
    } panel_t;

    // Higher value wins when several panel edges land in the same clock.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_STEP = 2'd1,
        OP_EXAM = 2'd2,
        OP_DEP  = 2'd3
    } panel_op_t;

    function automatic panel_op_t pick_op(input logic dep, input logic exam, input logic step);
        if (dep)  return OP_DEP;
        if (exam) return OP_EXAM;
        if (step) return OP_STEP;
        return OP_NONE;
    endfunction

    // nor/add/shr run the bit-serial ALU after EXEC; ld and the o2 class do not.
    function automatic logic uses_alu(input logic o2, input logic o1, input logic o0);
        return ~o2 & (o1 | o0);
    endfunction

endpackage

// File: rtl/q2_panel_sync.sv
// Multi-flop synchronizer for one asynchronous panel input, with optional rising-edge detect.
module q2_panel_sync #(
    parameter int   STAGES      = 2,
    parameter bit   DETECT_RISE = 1'b1,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    logic [STAGES-1:0] sync_q;

    // NOTE: clocked state is written with non-blocking assignments so every flop
    // in the chain samples the value from before this edge, not its neighbour's new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], raw};
        end
    end

    generate
        if (DETECT_RISE) begin : g_rise
            logic hist_q;

            // Resetting the history high means a button held through reset is not an edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hist_q <= RST_VAL;
                end else begin
                    hist_q <= sync_q[STAGES-1];
                end
            end

            assign clean = sync_q[STAGES-1] & ~hist_q;
        end else begin : g_level
            assign clean = sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/q2_sequencer.sv
// Q2 CPU cycle sequencer: walks FETCH/DEREF/LOAD/EXEC/SHIFT/FINAL with a write-strobe phase,
// and turns front-panel run/step/deposit/examine into control pulses.
module q2_sequencer
    import q2_pkg::*;
#(
    parameter int ALU_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run_sw,
    input  logic step_btn,
    input  logic dep_btn,
    input  logic exam_btn,
    input  logic deref,
    input  logic o0,
    input  logic o1,
    input  logic o2,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic ws,
    output logic dep_sw,
    output logic incp_db,
    output logic halted
);

    localparam int CNT_W = $clog2(ALU_BITS);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(ALU_BITS - 2);

    logic run_lvl;
    logic step_rise;
    logic dep_rise;
    logic exam_rise;

    q2_panel_sync #(.STAGES(SYNC_STAGES), .DETECT_RISE(1'b0), .RST_VAL(1'b0)) u_run_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (run_sw),
        .clean (run_lvl)
    );

    q2_panel_sync #(.STAGES(SYNC_STAGES), .DETECT_RISE(1'b1), .RST_VAL(1'b1)) u_step_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (step_btn),
        .clean (step_rise)
    );

    q2_panel_sync #(.STAGES(SYNC_STAGES), .DETECT_RISE(1'b1), .RST_VAL(1'b1)) u_dep_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (dep_btn),
        .clean (dep_rise)
    );

    q2_panel_sync #(.STAGES(SYNC_STAGES), .DETECT_RISE(1'b1), .RST_VAL(1'b1)) u_exam_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (exam_btn),
        .clean (exam_rise)
    );

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    panel_t           pnl_q, pnl_d;
    logic             step_pend_q, step_pend_d;
    logic             ws_q;

    logic      parked;
    logic      pnl_idle;
    logic      go;
    panel_op_t op;

    assign parked   = (state_q == ST_FETCH) && (phase_q == PH0);
    assign pnl_idle = (pnl_q == PNL_IDLE);
    // A panel pulse sequence in flight blocks both run and a pending step.
    assign go       = pnl_idle && (run_lvl || step_pend_q);
    assign halted   = parked && !go;
    assign op       = (halted && pnl_idle) ? pick_op(dep_rise, exam_rise, step_rise) : OP_NONE;

    // NOTE: every signal driven here gets its default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        unique case (phase_q)
            PH0: begin
                if (!parked || go) phase_d = PH1;
            end
            PH1: begin
                if (state_q == ST_FETCH) begin
                    phase_d = PH2;
                end else begin
                    phase_d = PH0;
                    case (state_q)
                        ST_DEREF: state_d = o2 ? ST_EXEC : ST_LOAD;
                        ST_LOAD:  state_d = ST_EXEC;
                        ST_EXEC:  state_d = uses_alu(o2, o1, o0) ? ST_SHIFT : ST_FETCH;
                        ST_SHIFT: begin
                            if (cnt_q == SHIFT_LAST) begin
                                cnt_d   = '0;
                                state_d = ST_FINAL;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        default:  state_d = ST_FETCH;
                    endcase
                end
            end
            PH2: begin
                // O was written during FETCH phase1, so the opcode is only trusted here.
                phase_d = PH0;
                if (deref)    state_d = ST_DEREF;
                else if (!o2) state_d = ST_LOAD;
                else          state_d = ST_EXEC;
            end
            default: begin
                phase_d = PH0;
                state_d = ST_FETCH;
            end
        endcase
    end

    always_comb begin
        pnl_d       = pnl_q;
        step_pend_d = step_pend_q;
        unique case (pnl_q)
            PNL_IDLE: begin
                if (op == OP_DEP)       pnl_d = PNL_DEP;
                else if (op == OP_EXAM) pnl_d = PNL_INC;
            end
            PNL_DEP: pnl_d = PNL_INC;
            PNL_INC: pnl_d = PNL_IDLE;
            default: pnl_d = PNL_IDLE;
        endcase
        if (parked && go)       step_pend_d = 1'b0;
        else if (op == OP_STEP) step_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            phase_q     <= PH0;
            cnt_q       <= '0;
            ws_q        <= 1'b0;
            pnl_q       <= PNL_IDLE;
            step_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            ws_q        <= (phase_d == PH1);
            pnl_q       <= pnl_d;
            step_pend_q <= step_pend_d;
        end
    end

    assign {s3, s2, s1, s0} = state_q;
    assign ws               = ws_q;
    assign dep_sw           = (pnl_q == PNL_DEP);
    assign incp_db          = (pnl_q == PNL_INC);

endmodule
